// File: rtl/recip_div_unit.sv
// Reciprocal engine: reads a 16-bit divisor from data memory, computes floor(2^15 / divisor)
// with a 16-step restoring division, writes it back and raises Ack.
module recip_div_unit #(
  parameter int ADDR_W   = 8,
  parameter int DIV_ADDR = 8,
  parameter int RES_ADDR = 10
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  output logic              Ack,
  output logic              Busy,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic              Mem_RdEn,
  input  logic [7:0]        Mem_RdData,
  output logic              Mem_WrEn,
  output logic [7:0]        Mem_WrData
);

  localparam logic [ADDR_W-1:0] DIV_A0 = ADDR_W'(DIV_ADDR);
  localparam logic [ADDR_W-1:0] DIV_A1 = ADDR_W'(DIV_ADDR + 1);
  localparam logic [ADDR_W-1:0] RES_A0 = ADDR_W'(RES_ADDR);
  localparam logic [ADDR_W-1:0] RES_A1 = ADDR_W'(RES_ADDR + 1);

  typedef enum logic [2:0] {IDLE, RD_HI, RD_LO, CAP, DIV, WR_HI, WR_LO, DONE} state_t;

  state_t      state, state_nx;
  logic        start_d;
  logic [15:0] divisor;
  logic [15:0] rem;
  logic [15:0] q;
  logic [15:0] dvd;
  logic [3:0]  count;

  logic        launch;
  logic [15:0] div_full;
  logic [16:0] t;
  logic        ge;
  logic [15:0] rem_nx;

  assign launch   = start_d & ~Start;
  assign div_full = {divisor[15:8], Mem_RdData};

  // Dividend 0x8000 is shifted in MSB first, so 16 steps leave floor(2^15/d) in q.
  assign t      = {rem, dvd[15]};
  assign ge     = t >= {1'b0, divisor};
  assign rem_nx = ge ? 16'(t - {1'b0, divisor}) : t[15:0];

  always_comb begin
    state_nx = state;
    if (Start) state_nx = IDLE;
    else begin
      case (state)
        IDLE:    if (launch) state_nx = RD_HI;
        RD_HI:   state_nx = RD_LO;
        RD_LO:   state_nx = CAP;
        CAP:     state_nx = (div_full == 16'h0) ? WR_HI : DIV;
        DIV:     if (count == 4'd15) state_nx = WR_HI;
        WR_HI:   state_nx = WR_LO;
        WR_LO:   state_nx = DONE;
        DONE:    if (launch) state_nx = RD_HI;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state   <= IDLE;
      start_d <= 1'b1;
      divisor <= '0;
      rem     <= '0;
      q       <= '0;
      dvd     <= '0;
      count   <= '0;
    end else begin
      state   <= state_nx;
      start_d <= Start;
      case (state)
        RD_LO: divisor[15:8] <= Mem_RdData;
        CAP: begin
          divisor[7:0] <= Mem_RdData;
          rem          <= '0;
          dvd          <= 16'h8000;
          count        <= '0;
          q            <= (div_full == 16'h0) ? 16'hFFFF : 16'h0000;
        end
        DIV: begin
          rem   <= rem_nx;
          q     <= {q[14:0], ge};
          dvd   <= {dvd[14:0], 1'b0};
          count <= count + 4'd1;
        end
        default: ;
      endcase
    end
  end

  // Moore outputs: everything decodes from state, so reset zeroes them immediately.
  always_comb begin
    Ack        = 1'b0;
    Busy       = 1'b0;
    Mem_Addr   = '0;
    Mem_RdEn   = 1'b0;
    Mem_WrEn   = 1'b0;
    Mem_WrData = '0;
    case (state)
      RD_HI: begin Busy = 1'b1; Mem_Addr = DIV_A0; Mem_RdEn = 1'b1; end
      RD_LO: begin Busy = 1'b1; Mem_Addr = DIV_A1; Mem_RdEn = 1'b1; end
      CAP:   Busy = 1'b1;
      DIV:   Busy = 1'b1;
      WR_HI: begin Busy = 1'b1; Mem_Addr = RES_A0; Mem_WrEn = 1'b1; Mem_WrData = q[15:8]; end
      WR_LO: begin Busy = 1'b1; Mem_Addr = RES_A1; Mem_WrEn = 1'b1; Mem_WrData = q[7:0]; end
      DONE:  Ack = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_recip_div_unit.sv
// Bench for recip_div_unit: byte memory model, vector table with scoreboard, abort and reset sequences.
module tb_recip_div_unit;

  logic       clk, rst_n, start;
  logic       ack, busy, rden, wren;
  logic [7:0] addr, rdata, wdata;

  logic [7:0] mem [256];
  int         wr_cnt;
  logic       host_we;
  logic [7:0] host_a, host_d;

  int cmp_cnt, mis_cnt;
  logic [15:0] sb [$];

  typedef struct {
    logic [15:0] d;
    logic [15:0] q;
    int          lat;
  } vec_t;
  vec_t vecs [12];

  recip_div_unit #(.ADDR_W(8), .DIV_ADDR(8), .RES_ADDR(10)) dut (
    .Clk(clk), .Reset(rst_n), .Start(start), .Ack(ack), .Busy(busy),
    .Mem_Addr(addr), .Mem_RdEn(rden), .Mem_RdData(rdata),
    .Mem_WrEn(wren), .Mem_WrData(wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial wr_cnt = 0;
  always @(posedge clk) begin
    if (host_we) mem[host_a] <= host_d;
    else if (wren) begin
      mem[addr] <= wdata;
      wr_cnt    <= wr_cnt + 1;
    end
    if (rden) rdata <= mem[addr];
  end

  task automatic check(input string nm, input int got, input int exp);
    cmp_cnt++;
    if (got !== exp) begin
      mis_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    end
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    host_we = 1'b1; host_a = a; host_d = d;
    @(posedge clk); #1;
    host_we = 1'b0;
  endtask

  task automatic load(input logic [15:0] d);
    poke(8'd8, d[15:8]);
    poke(8'd9, d[7:0]);
    poke(8'd10, 8'hA5);
    poke(8'd11, 8'h5A);
  endtask

  task automatic run_vec(input logic [15:0] d, input logic [15:0] q, input int lat);
    int n, wb, viol;
    logic [15:0] exp, got;
    load(d);
    @(negedge clk);
    wb = wr_cnt; n = 0; viol = 0;
    sb.push_back(q);
    start = 1'b0;
    while (!ack && n < 100) begin
      @(posedge clk); n++;
      @(negedge clk);
      if ((ack && wren) || (rden && wren)) viol++;
    end
    check("ack_latency", n, lat);
    exp = sb.pop_front();
    got = {mem[10], mem[11]};
    check("result", int'(got), int'(exp));
    check("write_strobes", wr_cnt - wb, 2);
    check("strobe_exclusion", viol, 0);
    start = 1'b1;
    @(posedge clk); @(negedge clk);
    check("ack_drop", int'(ack), 0);
  endtask

  initial begin
    int wb;
    cmp_cnt = 0; mis_cnt = 0;
    host_we = 1'b0; host_a = '0; host_d = '0;
    vecs[0]  = '{16'h0004, 16'h2000, 22};
    vecs[1]  = '{16'h0003, 16'h2AAA, 22};
    vecs[2]  = '{16'h0001, 16'h8000, 22};
    vecs[3]  = '{16'h0007, 16'h1249, 22};
    vecs[4]  = '{16'h0000, 16'hFFFF, 6};
    vecs[5]  = '{16'hFFFF, 16'h0000, 22};
    vecs[6]  = '{16'h8000, 16'h0001, 22};
    vecs[7]  = '{16'h00FF, 16'h0080, 22};
    vecs[8]  = '{16'h8001, 16'h0000, 22};
    vecs[9]  = '{16'h7FFF, 16'h0001, 22};
    vecs[10] = '{16'h0002, 16'h4000, 22};
    vecs[11] = '{16'h0100, 16'h0080, 22};

    start = 1'b1;
    rst_n = 1'b0;
    #20;
    check("rst_ack", int'(ack), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_strobes", int'({rden, wren}), 0);
    check("rst_addr", int'(addr), 0);
    check("rst_wdata", int'(wdata), 0);
    @(negedge clk); rst_n = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i].d, vecs[i].q, vecs[i].lat);

    // abort on the 5th DIV cycle
    load(16'h0003);
    @(negedge clk);
    wb = wr_cnt;
    start = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("abort_busy_before", int'(busy), 1);
    start = 1'b1;
    @(posedge clk); @(negedge clk);
    check("abort_ack", int'(ack), 0);
    check("abort_busy", int'(busy), 0);
    repeat (30) @(negedge clk);
    check("abort_writes", wr_cnt - wb, 0);
    check("abort_mem", int'({mem[10], mem[11]}), 16'hA55A);
    run_vec(16'h0003, 16'h2AAA, 22);

    // async reset mid-DIV
    load(16'h0007);
    @(negedge clk);
    wb = wr_cnt;
    start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("rstmid_busy_before", int'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid_busy", int'(busy), 0);
    check("rstmid_strobes", int'({rden, wren, ack}), 0);
    check("rstmid_addr", int'(addr), 0);
    start = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    repeat (25) @(negedge clk);
    check("rstmid_writes", wr_cnt - wb, 0);
    check("rstmid_mem", int'({mem[10], mem[11]}), 16'hA55A);

    run_vec(16'h0004, 16'h2000, 22);
    run_vec(16'h0007, 16'h1249, 22);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
    $finish;
  end

endmodule
